mem_arbiter: RTL
================

# mem_arbiter

Shares the single external memory port between the instruction-fetch requester (iddr) and the data-memory requester (dddr). Sits between the ifetch/mem pipeline stages and the memory controller. Data accesses have priority, with a streak limit that guarantees fetch progress. Each requester sees a hold-until-resp handshake; the memory side sees one registered, stable request at a time.

## Interface
- BYTES_PER_WORD, 4, word size in bytes; also the width of the byte-write mask.
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- iddr_addr  in  32  fetch address (rvga_word).
- iddr_read  in  1  fetch request; held with address until iddr_resp.
- iddr_rdata  out  32  fetched word; valid when iddr_resp=1.
- iddr_resp  out  1  one-cycle completion pulse.
- dddr_addr  in  32  data address.
- dddr_read  in  1  data read request.
- dddr_write  in  1  data write request.
- dddr_wdata  in  32  write data.
- dddr_wmask  in  BYTES_PER_WORD  byte enables.
- dddr_rdata  out  32  read data; valid when dddr_resp=1.
- dddr_resp  out  1  one-cycle completion pulse.
- mem_addr / mem_wdata  out  32  registered request to memory.
- mem_read / mem_write  out  1  registered strobes; held until mem_resp.
- mem_wmask  out  BYTES_PER_WORD  registered byte enables.
- mem_rdata  in  32  memory read data, valid with mem_resp.
- mem_resp  in  1  memory completion pulse.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, DONE. Reset → IDLE.
- IDLE, grant decision:
  - dddr request and (iddr_read=0 or streak<MAX_D_STREAK) → SERVE_D.
  - Else if iddr_read → SERVE_I.
  - Else stay in IDLE.
- On grant, latch addr/wdata/wmask and the read/write strobe into the mem_* registers. Instruction grants force mem_write=0 and mem_wmask=0.
- dddr_read and dddr_write asserted together: treated as a write; the read is ignored.
- SERVE_x: mem_* held constant. On mem_resp:
  - Capture mem_rdata into the granted requester's rdata register. Write grants capture too; the value is don't-care.
  - Clear mem_read/mem_write.
  - Pulse that requester's resp next cycle.
  - Go to DONE.
- DONE: resp pulse is high this cycle; no grant is made. Next state is IDLE. A requester must drop or change its request in the cycle after its resp.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - Data grant with iddr_read=1 → increment, saturating.
  - Data grant with iddr_read=0 → clear.
  - Instruction grant → clear.
- rdata registers hold their last value between responses.
- mem_resp outside SERVE_x: ignored.

## Timing
- Reset values:
  - All outputs 0: mem_*, iddr_rdata, iddr_resp, dddr_rdata, dddr_resp.
  - streak=0, state=IDLE.
- Request sampled in IDLE at cycle N → mem strobe high at N+1.
- mem_resp at cycle M → requester resp and rdata at M+1 (DONE) → IDLE at M+2.
- Minimum occupancy per access: 3 cycles + memory latency. Zero-wait memory (mem_resp at N+1) → resp at N+2.
- Reset mid-transaction: next edge returns to IDLE with all outputs 0; the in-flight access is abandoned. A later mem_resp is ignored.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Structure
- rvga_types package:
  - rvga_word.
  - mem_arb_state_t enum {IDLE, SERVE_I, SERVE_D, DONE}.
  - mem_req_t struct {addr, wdata, wmask, read, write}; the mem_* registers are one mem_req_t.
- BYTES_PER_WORD comes from rvga_params.
- Single module; no sub-module. The priority decision is one combinational block and the FSM and registers are a second.

## Test plan
- Fetch only: iddr_addr=0x100, iddr_read=1, memory responds 2 cycles after the strobe with 0xDEADBEEF → mem_read=1, mem_addr=0x100 at N+1; iddr_resp=1 and iddr_rdata=0xDEADBEEF at N+4, one cycle only.
- Collision: iddr_read and dddr_read (0x2000) asserted the same cycle → data served first. The fetch's mem_read rises 2 cycles after dddr_resp.
- Starvation: dddr_write continuous while iddr_read held, MAX_D_STREAK=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Write path: dddr_write=1, wdata=0x12345678, wmask=4'b0011 → mem_write=1 with identical wdata/wmask, mem_read=0. dddr_resp pulses one cycle after mem_resp.
- Read and write together: dddr_read=dddr_write=1 → only mem_write=1.
- Reset mid-access: rst_n=0 while in SERVE_D, then mem_resp after reset → all outputs 0, no resp pulse; the next fetch is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared word/request types and bus parameters for the memory arbiter slice.
package rvga_params;
    localparam int BYTES_PER_WORD = 4;
endpackage

package rvga_types;
    import rvga_params::*;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } mem_arb_state_t;

    typedef struct packed {
        rvga_word                  addr;
        rvga_word                  wdata;
        logic [BYTES_PER_WORD-1:0] wmask;
        logic                      read;
        logic                      write;
    } mem_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Word-wide request/response bus; master issues, slave completes with a resp pulse.
interface mem_arbiter_if #(
    parameter int BYTES_PER_WORD = rvga_params::BYTES_PER_WORD
);
    import rvga_types::*;

    rvga_word                  addr;
    rvga_word                  wdata;
    logic [BYTES_PER_WORD-1:0] wmask;
    logic                      read;
    logic                      write;
    rvga_word                  rdata;
    logic                      resp;

    modport master (
        output addr, wdata, wmask, read, write,
        input  rdata, resp
    );

    modport slave (
        input  addr, wdata, wmask, read, write,
        output rdata, resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data; data wins, bounded by a
// streak limit so a waiting fetch always gets through.
module mem_arbiter
    import rvga_types::*;
#(
    parameter int BYTES_PER_WORD = rvga_params::BYTES_PER_WORD,
    parameter int MAX_D_STREAK   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  iddr,
    mem_arbiter_if.slave  dddr,
    mem_arbiter_if.master mem
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    mem_arb_state_t r_state;
    mem_req_t       r_req;
    logic [SW-1:0]  r_streak;
    rvga_word       r_irdata;
    rvga_word       r_drdata;
    logic           r_iresp;
    logic           r_dresp;

    logic                      w_d_req;
    logic                      w_grant_d;
    logic                      w_grant_i;
    logic [BYTES_PER_WORD-1:0] w_dmask;

    assign w_dmask = dddr.wmask;

    always_comb begin
        w_d_req   = dddr.read | dddr.write;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (r_state == IDLE) begin
            if (w_d_req && (!iddr.read || r_streak < STREAK_MAX))
                w_grant_d = 1'b1;
            else if (iddr.read)
                w_grant_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_streak <= '0;
            r_irdata <= '0;
            r_drdata <= '0;
            r_iresp  <= 1'b0;
            r_dresp  <= 1'b0;
        end else begin
            r_iresp <= 1'b0;
            r_dresp <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        // a combined read+write is issued as a pure write
                        r_req.addr  <= dddr.addr;
                        r_req.wdata <= dddr.wdata;
                        r_req.wmask <= w_dmask;
                        r_req.write <= dddr.write;
                        r_req.read  <= dddr.read & ~dddr.write;
                        r_state     <= SERVE_D;
                        if (!iddr.read)
                            r_streak <= '0;
                        else if (r_streak < STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                    end else if (w_grant_i) begin
                        r_req.addr  <= iddr.addr;
                        r_req.wdata <= '0;
                        r_req.wmask <= '0;
                        r_req.write <= 1'b0;
                        r_req.read  <= 1'b1;
                        r_state     <= SERVE_I;
                        r_streak    <= '0;
                    end
                end
                SERVE_I: begin
                    if (mem.resp) begin
                        r_irdata    <= mem.rdata;
                        r_req.read  <= 1'b0;
                        r_req.write <= 1'b0;
                        r_iresp     <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                SERVE_D: begin
                    if (mem.resp) begin
                        r_drdata    <= mem.rdata;
                        r_req.read  <= 1'b0;
                        r_req.write <= 1'b0;
                        r_dresp     <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.addr   = r_req.addr;
    assign mem.wdata  = r_req.wdata;
    assign mem.wmask  = r_req.wmask;
    assign mem.read   = r_req.read;
    assign mem.write  = r_req.write;
    assign iddr.rdata = r_irdata;
    assign iddr.resp  = r_iresp;
    assign dddr.rdata = r_drdata;
    assign dddr.resp  = r_dresp;

endmodule
